// File: rtl/bandit_environment_if.sv
// Action/reward handshake bundle between the bandit learner (master)
// and the stochastic reward environment (slave).
interface bandit_environment_if;
    logic       action_valid;
    logic [7:0] action_data;
    logic       action_ready;
    logic       reward_valid;
    logic [7:0] reward_data;
    logic       reward_ready;

    modport master (
        output action_valid,
        output action_data,
        output reward_ready,
        input  action_ready,
        input  reward_valid,
        input  reward_data
    );

    modport slave (
        input  action_valid,
        input  action_data,
        input  reward_ready,
        output action_ready,
        output reward_valid,
        output reward_data
    );
endinterface

// File: rtl/bandit_environment.sv
// Stochastic reward source for the bandit learner: per-action base reward plus
// LFSR noise, saturated to signed 8 bits and returned after a fixed latency.
module bandit_environment #(
    parameter int          LATENCY     = 2,
    parameter int          NOISE_BITS  = 4,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    bandit_environment_if.slave    bus,
    input  logic [7:0]             best_action,
    input  logic [7:0]             best_reward,
    input  logic [7:0]             other_reward,
    output logic [COUNT_WIDTH-1:0] trial_count,
    output logic [COUNT_WIDTH-1:0] hit_count
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        REWARD
    } state_t;

    localparam logic [7:0] LAT_INIT = 8'(LATENCY - 1);
    localparam int         SIGN_IDX = (NOISE_BITS > 0) ? NOISE_BITS - 1 : 0;

    state_t                 state;
    logic [15:0]            lfsr;
    logic [15:0]            lfsr_next;
    logic [7:0]             lat_count;
    logic                   is_best;
    logic [7:0]             pending_reward;
    logic                   action_ready;
    logic                   reward_valid;
    logic [7:0]             reward_data;
    logic                   accept_is_best;
    logic [7:0]             base_reward;
    logic signed [8:0]      noise;
    logic signed [8:0]      sum;
    logic [7:0]             saturated;

    assign bus.action_ready = action_ready;
    assign bus.reward_valid = reward_valid;
    assign bus.reward_data  = reward_data;

    // Galois LFSR, x^16+x^14+x^13+x^11+1, right-shifting with mask 16'hB400.
    assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

    // The reward is fully determined at the accept edge, so it is computed
    // there and parked; later config changes cannot reach an in-flight reward.
    always_comb begin
        accept_is_best = (bus.action_data == best_action);
        base_reward    = accept_is_best ? best_reward : other_reward;
        noise          = '0;
        if (NOISE_BITS > 0) begin
            for (int i = 0; i < 9; i++) begin
                noise[i] = (i < NOISE_BITS) ? lfsr[i] : lfsr[SIGN_IDX];
            end
        end
        sum = $signed({base_reward[7], base_reward}) + noise;
        if (sum > 9'sd127) begin
            saturated = 8'h7F;
        end else if (sum < -9'sd128) begin
            saturated = 8'h80;
        end else begin
            saturated = sum[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            lfsr           <= SEED;
            lat_count      <= '0;
            is_best        <= 1'b0;
            pending_reward <= '0;
            action_ready   <= 1'b0;
            reward_valid   <= 1'b0;
            reward_data    <= '0;
            trial_count    <= '0;
            hit_count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (action_ready && bus.action_valid) begin
                        is_best        <= accept_is_best;
                        pending_reward <= saturated;
                        lfsr           <= lfsr_next;
                        lat_count      <= LAT_INIT;
                        action_ready   <= 1'b0;
                        state          <= WAIT;
                    end else begin
                        action_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (lat_count == 8'd0) begin
                        reward_valid <= 1'b1;
                        reward_data  <= pending_reward;
                        state        <= REWARD;
                    end else begin
                        lat_count <= lat_count - 8'd1;
                    end
                end
                REWARD: begin
                    if (bus.reward_ready) begin
                        reward_valid <= 1'b0;
                        action_ready <= 1'b1;
                        state        <= IDLE;
                        // Counters stick at all-ones rather than wrapping.
                        if (trial_count != '1) begin
                            trial_count <= trial_count + 1'b1;
                        end
                        if (is_best && (hit_count != '1)) begin
                            hit_count <= hit_count + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bandit_environment.sv
// Directed bench for bandit_environment: a noiseless instance for exact rewards
// and a 4-bit-noise instance checked against hand-computed LFSR noise.
module tb_bandit_environment;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  best_action  = 8'd5;
    logic [7:0]  best_reward  = 8'd64;
    logic [7:0]  other_reward = 8'hE0;
    logic [31:0] trial0, hit0, trial4, hit4;

    int vectors     = 0;
    int miscompares = 0;

    bandit_environment_if if0 ();
    bandit_environment_if if4 ();

    bandit_environment #(.LATENCY(2), .NOISE_BITS(0), .SEED(16'hACE1), .COUNT_WIDTH(32)) dut0 (
        .clock        (clock),
        .reset        (reset),
        .bus          (if0.slave),
        .best_action  (best_action),
        .best_reward  (best_reward),
        .other_reward (other_reward),
        .trial_count  (trial0),
        .hit_count    (hit0)
    );

    bandit_environment #(.LATENCY(2), .NOISE_BITS(4), .SEED(16'hACE1), .COUNT_WIDTH(32)) dut4 (
        .clock        (clock),
        .reset        (reset),
        .bus          (if4.slave),
        .best_action  (best_action),
        .best_reward  (best_reward),
        .other_reward (other_reward),
        .trial_count  (trial4),
        .hit_count    (hit4)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic get_aready(input bit u);
        return u ? if4.action_ready : if0.action_ready;
    endfunction

    function automatic logic get_rvalid(input bit u);
        return u ? if4.reward_valid : if0.reward_valid;
    endfunction

    function automatic logic [7:0] get_rdata(input bit u);
        return u ? if4.reward_data : if0.reward_data;
    endfunction

    task automatic drive_action(input bit u, input logic v, input logic [7:0] d);
        if (u) begin
            if4.action_valid = v;
            if4.action_data  = d;
        end else begin
            if0.action_valid = v;
            if0.action_data  = d;
        end
    endtask

    task automatic drive_ready(input bit u, input logic v);
        if (u) if4.reward_ready = v;
        else   if0.reward_ready = v;
    endtask

    task automatic accept_action(input bit u, input logic [7:0] act, output bit to);
        int n = 0;
        to = 1'b0;
        while (!get_aready(u) && n < 10) begin
            step();
            n++;
        end
        if (!get_aready(u)) begin
            to = 1'b1;
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: action_ready=%b required 1", get_aready(u));
            return;
        end
        drive_action(u, 1'b1, act);
        step();
        drive_action(u, 1'b0, 8'h00);
    endtask

    task automatic wait_reward(input bit u, output int lat, output bit to);
        lat = 0;
        to  = 1'b0;
        while (!get_rvalid(u) && lat < 10) begin
            step();
            lat++;
        end
        if (!get_rvalid(u)) begin
            to = 1'b1;
            vectors++;
            miscompares++;
            $display("[TB] FAIL reward_timeout: reward_valid=%b required 1", get_rvalid(u));
        end
    endtask

    task automatic handshake(input bit u);
        drive_ready(u, 1'b1);
        step();
        drive_ready(u, 1'b0);
    endtask

    task automatic xact(input bit u, input logic [7:0] act, output int lat,
                        output logic [7:0] rew, output bit to);
        rew = 8'hxx;
        lat = -1;
        accept_action(u, act, to);
        if (to) return;
        wait_reward(u, lat, to);
        if (to) return;
        rew = get_rdata(u);
        handshake(u);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        vectors++;
        if (if0.action_ready !== 1'b0 || if0.reward_valid !== 1'b0 || if0.reward_data !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: ready=%b valid=%b data=%h required 0 0 00",
                     if0.action_ready, if0.reward_valid, if0.reward_data);
        end
        vectors++;
        if (trial0 !== 32'd0 || hit0 !== 32'd0 || if4.action_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_counters: trial=%0d hit=%0d ready4=%b required 0 0 0",
                     trial0, hit0, if4.action_ready);
        end
        reset = 1'b0;
        step();
        vectors++;
        if (if0.action_ready !== 1'b1 || if4.action_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_release_ready: ready0=%b ready4=%b required 1 1",
                     if0.action_ready, if4.action_ready);
        end
    endtask

    task automatic test_basic();
        int lat; logic [7:0] rew; bit to;
        accept_action(0, 8'd5, to);
        vectors++;
        if (if0.action_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_ready_after_accept: got %b want 0", if0.action_ready);
        end
        wait_reward(0, lat, to);
        rew = if0.reward_data;
        handshake(0);
        vectors++;
        if (lat !== 2 || rew !== 8'h40) begin
            miscompares++;
            $display("[TB] FAIL basic_best: latency=%0d reward=%h want 2 40", lat, rew);
        end
        vectors++;
        if (trial0 !== 32'd1 || hit0 !== 32'd1) begin
            miscompares++;
            $display("[TB] FAIL basic_best_counts: trial=%0d hit=%0d want 1 1", trial0, hit0);
        end
        xact(0, 8'd7, lat, rew, to);
        vectors++;
        if (lat !== 2 || rew !== 8'hE0 || trial0 !== 32'd2 || hit0 !== 32'd1) begin
            miscompares++;
            $display("[TB] FAIL basic_other: lat=%0d rew=%h trial=%0d hit=%0d want 2 e0 2 1",
                     lat, rew, trial0, hit0);
        end
        best_action = 8'd0;
        xact(0, 8'd0, lat, rew, to);
        vectors++;
        if (rew !== 8'h40 || trial0 !== 32'd3 || hit0 !== 32'd2) begin
            miscompares++;
            $display("[TB] FAIL basic_action_zero: rew=%h trial=%0d hit=%0d want 40 3 2",
                     rew, trial0, hit0);
        end
        best_action = 8'd5;
    endtask

    task automatic test_backpressure();
        int lat; bit to; int bad = 0;
        accept_action(0, 8'd7, to);
        wait_reward(0, lat, to);
        drive_action(0, 1'b1, 8'd5);
        for (int i = 0; i < 10; i++) begin
            step();
            if (if0.reward_valid !== 1'b1 || if0.reward_data !== 8'hE0 ||
                if0.action_ready !== 1'b0 || trial0 !== 32'd3) bad++;
        end
        drive_action(0, 1'b0, 8'h00);
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL backpressure_hold: %0d of 10 cycles changed, want 0", bad);
        end
        handshake(0);
        vectors++;
        if (if0.reward_valid !== 1'b0 || if0.action_ready !== 1'b1 ||
            trial0 !== 32'd4 || hit0 !== 32'd2) begin
            miscompares++;
            $display("[TB] FAIL backpressure_release: valid=%b ready=%b trial=%0d hit=%0d want 0 1 4 2",
                     if0.reward_valid, if0.action_ready, trial0, hit0);
        end
    endtask

    task automatic test_config_stability();
        int lat; logic [7:0] rew; bit to;
        accept_action(0, 8'd5, to);
        best_action  = 8'd9;
        best_reward  = 8'h00;
        other_reward = 8'h10;
        wait_reward(0, lat, to);
        rew = if0.reward_data;
        handshake(0);
        vectors++;
        if (rew !== 8'h40 || trial0 !== 32'd5 || hit0 !== 32'd3) begin
            miscompares++;
            $display("[TB] FAIL config_stability: rew=%h trial=%0d hit=%0d want 40 5 3",
                     rew, trial0, hit0);
        end
        best_action  = 8'd5;
        best_reward  = 8'd64;
        other_reward = 8'hE0;
    endtask

    // Expected noise from SEED 16'hACE1: +1, 0, -8, -4, then -2.
    task automatic test_noise();
        int lat; logic [7:0] rew; bit to;
        logic [7:0] acts [4] = '{8'd5, 8'd7, 8'd5, 8'd7};
        logic [7:0] exps [4] = '{8'h41, 8'hE0, 8'h38, 8'hDC};
        for (int i = 0; i < 4; i++) begin
            xact(1, acts[i], lat, rew, to);
            vectors++;
            if (lat !== 2 || rew !== exps[i]) begin
                miscompares++;
                $display("[TB] FAIL noise_%0d: lat=%0d rew=%h want 2 %h", i, lat, rew, exps[i]);
            end
        end
        vectors++;
        if (trial4 !== 32'd4 || hit4 !== 32'd2) begin
            miscompares++;
            $display("[TB] FAIL noise_counts: trial=%0d hit=%0d want 4 2", trial4, hit4);
        end
    endtask

    task automatic test_reset_mid_wait();
        int lat; logic [7:0] rew; bit to;
        accept_action(1, 8'd5, to);
        reset = 1'b1;
        step();
        vectors++;
        if (if4.reward_valid !== 1'b0 || if4.action_ready !== 1'b0 || if4.reward_data !== 8'h00 ||
            trial4 !== 32'd0 || hit4 !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL midwait_reset: valid=%b ready=%b data=%h trial=%0d hit=%0d want 0 0 00 0 0",
                     if4.reward_valid, if4.action_ready, if4.reward_data, trial4, hit4);
        end
        reset = 1'b0;
        step();
        vectors++;
        if (if4.action_ready !== 1'b1 || if4.reward_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midwait_release: ready=%b valid=%b want 1 0",
                     if4.action_ready, if4.reward_valid);
        end
        xact(1, 8'd5, lat, rew, to);
        vectors++;
        if (lat !== 2 || rew !== 8'h41 || trial4 !== 32'd1 || hit4 !== 32'd1) begin
            miscompares++;
            $display("[TB] FAIL midwait_seed_replay: lat=%0d rew=%h trial=%0d hit=%0d want 2 41 1 1",
                     lat, rew, trial4, hit4);
        end
    endtask

    task automatic test_saturation();
        int lat; logic [7:0] rew; bit to;
        best_reward = 8'h7F;
        for (int i = 0; i < 1000; i++) begin
            xact(1, 8'd5, lat, rew, to);
            vectors++;
            if (to || $signed(rew) < 8'sd119) begin
                miscompares++;
                $display("[TB] FAIL sat_high_%0d: rew=%0d want 119..127", i, $signed(rew));
                break;
            end
        end
        best_reward = 8'h80;
        for (int i = 0; i < 1000; i++) begin
            xact(1, 8'd5, lat, rew, to);
            vectors++;
            if (to || $signed(rew) > -8'sd121) begin
                miscompares++;
                $display("[TB] FAIL sat_low_%0d: rew=%0d want -128..-121", i, $signed(rew));
                break;
            end
        end
        vectors++;
        if (trial4 !== 32'd2001 || hit4 !== 32'd2001) begin
            miscompares++;
            $display("[TB] FAIL sat_counts: trial=%0d hit=%0d want 2001 2001", trial4, hit4);
        end
        best_reward = 8'd64;
    endtask

    initial begin
        drive_action(0, 1'b0, 8'h00);
        drive_action(1, 1'b0, 8'h00);
        drive_ready(0, 1'b0);
        drive_ready(1, 1'b0);
        test_reset();
        test_basic();
        test_backpressure();
        test_config_stability();
        test_noise();
        test_reset_mid_wait();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bandit_environment.md
Name: bandit_environment

Overview:
- Stochastic reward source that closes the loop around the bandit learner.
- Consumes the learner's 8-bit action stream and looks up a per-action base reward (one configurable "best" action, all others share a second value).
- Adds bounded pseudo-random noise, then returns a saturated signed 8-bit reward on a valid/ready handshake after a fixed latency.
- Keeps trial and hit counters so on-chip runs can measure convergence without a bench.

Parameters:
- LATENCY, 2: cycles from action handshake edge to first cycle reward_valid is high; legal range 1..255.
- NOISE_BITS, 4: width of signed noise taken from LFSR bits [NOISE_BITS-1:0]; 0 disables noise; legal range 0..7.
- SEED, 16'hACE1: LFSR reset value; must be nonzero.
- COUNT_WIDTH, 32: width of trial_count and hit_count.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- action_valid  input  1  learner presents an action.
- action_data  input  8  action index, unsigned.
- action_ready  output  1  environment accepts an action.
- reward_valid  output  1  reward presented.
- reward_data  output  8  reward, signed two's complement.
- reward_ready  input  1  learner accepts the reward.
- best_action  input  8  index of the preferred action.
- best_reward  input  8  signed base reward for best_action.
- other_reward  input  8  signed base reward for every other action.
- trial_count  output  COUNT_WIDTH  completed reward handshakes.
- hit_count  output  COUNT_WIDTH  completed handshakes whose action equalled best_action.

Behaviour:
- Reset values:
  - action_ready=0, reward_valid=0, reward_data=0.
  - trial_count=0, hit_count=0, LFSR=SEED, state=IDLE.
  - Reset mid-operation abandons any pending action or reward with no counter update.
- States: IDLE, WAIT, REWARD. One transaction in flight at a time.
- IDLE:
  - action_ready=1, but only from the first cycle after reset deasserts (registered).
  - An action is accepted on a rising edge where action_valid&&action_ready.
  - On that edge:
    - Capture action_data.
    - Capture is_best=(action_data==best_action), comparing as unsigned; action 0 is handled like any other index.
    - Capture base reward = best_reward if is_best, else other_reward.
    - Capture noise from the current LFSR value, then advance the LFSR once.
    - Load the latency counter with LATENCY-1.
    - action_ready=0; go to WAIT.
  - best_action/best_reward/other_reward are sampled only at the accept edge; later changes do not affect an in-flight reward.
- WAIT:
  - Counter decrements each cycle; inputs ignored; action_ready=0.
  - On the edge where the counter is 0: reward_valid=1, reward_data=computed value, go to REWARD.
  - Net effect: handshake at edge N gives reward_valid visible after edge N+LATENCY.
  - For LATENCY=1 there are zero WAIT cycles: go directly to REWARD on the accept edge +1 (reward_valid high the cycle after accept).
- REWARD:
  - reward_valid and reward_data held stable until reward_ready; no change under backpressure.
  - On the edge with reward_valid&&reward_ready:
    - reward_valid=0.
    - trial_count+=1; hit_count+=1 if is_best.
    - action_ready=1; go to IDLE.
  - New action accepted no earlier than the edge after the reward handshake.
- Arithmetic:
  - noise = sign-extension of LFSR[NOISE_BITS-1:0] to 9 bits (range -2^(NOISE_BITS-1)..2^(NOISE_BITS-1)-1); noise=0 if NOISE_BITS=0.
  - sum = sign-extend(base,9) + noise.
  - reward_data = 127 if sum>127, -128 if sum<-128, else sum[7:0].
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Shift right; when the outgoing bit is 1, XOR mask 16'hB400.
  - Advances only on action accept.
- Counters saturate at all-ones; never wrap.
- action_valid deasserting while in WAIT/REWARD is legal and ignored.

Test Plan:
- NOISE_BITS=0, LATENCY=2, best_action=5, best_reward=64, other_reward=-32:
  - Send action 5 -> reward_data=64, reward_valid first high 2 cycles after accept edge; trial=1, hit=1.
  - Then send action 7 -> reward_data=-32 (0xE0); trial=2, hit=1.
- Saturation, NOISE_BITS=4:
  - best_reward=127 -> every reward in 1000 trials lies in [119,127], never wraps negative.
  - best_reward=-128 -> every reward in [-128,-121].
- Backpressure: hold reward_ready=0 for 10 cycles -> reward_valid and reward_data unchanged, action_ready=0 throughout; counters advance only on the ready edge.
- Config stability: change best_action from 5 to 9 during WAIT for action 5 -> reward still best_reward; hit_count increments.
- Reset mid-WAIT: assert reset for 1 cycle -> reward_valid=0, counters=0, action_ready=0 that cycle then 1 next; following transaction reproduces the first post-reset noise value (LFSR=SEED).
- Closed loop with the bandit learner for 16000 trials (best_reward=64, other_reward=-32, NOISE_BITS=4) -> hit_count over the last 1000 trials >=900.
